// File: rtl/maxnet_act_collector.sv
// Maxnet activation collector: gathers four PLU results per iteration into a shadow
// buffer, commits them as the activation vector and decides converge/timeout/iterate.
module maxnet_act_collector #(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_valid,
    output logic              init_ready,
    input  logic [31:0]       init_a1,
    input  logic [31:0]       init_a2,
    input  logic [31:0]       init_a3,
    input  logic [31:0]       init_a4,
    input  logic              plu_valid,
    input  logic [1:0]        plu_idx,
    input  logic [31:0]       plu_data,
    output logic [31:0]       a1,
    output logic [31:0]       a2,
    output logic [31:0]       a3,
    output logic [31:0]       a4,
    output logic              iter_start,
    output logic              done,
    output logic [1:0]        winner,
    output logic              zero_all,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_COLLECT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    state_t            state_q, state_d;
    logic [31:0]       act_q [4];
    logic [31:0]       act_d [4];
    logic [31:0]       shadow_q [4];
    logic [31:0]       shadow_d [4];
    logic [3:0]        mask_q, mask_d;
    logic              done_q, done_d;
    logic [1:0]        winner_q, winner_d;
    logic              zero_all_q, zero_all_d;
    logic              timeout_q, timeout_d;
    logic [ITER_W-1:0] iter_count_q, iter_count_d;

    logic [31:0]       init_vec [4];
    logic [3:0]        nz;
    logic [1:0]        low_idx;
    logic              at_most_one;
    logic [ITER_W-1:0] iter_inc;

    assign init_vec[0] = init_a1;
    assign init_vec[1] = init_a2;
    assign init_vec[2] = init_a3;
    assign init_vec[3] = init_a4;

    // Zero test only; the data format is never interpreted.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nz
            assign nz[gi] = (shadow_q[gi] != 32'h0);
        end
    endgenerate

    assign at_most_one = ((nz & (nz - 4'd1)) == 4'd0);
    assign iter_inc    = iter_count_q + 1'b1;

    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (nz[i]) low_idx = 2'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        shadow_d     = shadow_q;
        mask_d       = mask_q;
        done_d       = done_q;
        winner_d     = winner_q;
        zero_all_d   = zero_all_q;
        timeout_d    = timeout_q;
        iter_count_d = iter_count_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (init_valid) begin
                    act_d        = init_vec;
                    iter_count_d = '0;
                    done_d       = 1'b0;
                    winner_d     = 2'd0;
                    zero_all_d   = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                mask_d  = 4'd0;
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (plu_valid) begin
                    shadow_d[plu_idx] = plu_data;
                    mask_d[plu_idx]   = 1'b1;
                end
                if (mask_d == 4'hF) state_d = S_CHECK;
            end
            S_CHECK: begin
                act_d        = shadow_q;
                iter_count_d = iter_inc;
                if (at_most_one) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    winner_d   = low_idx;
                    zero_all_d = (nz == 4'd0);
                end else if (iter_inc == MAX_ITER_C) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    winner_d  = low_idx;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                act_q[i]    <= 32'h0;
                shadow_q[i] <= 32'h0;
            end
            mask_q       <= 4'd0;
            done_q       <= 1'b0;
            winner_q     <= 2'd0;
            zero_all_q   <= 1'b0;
            timeout_q    <= 1'b0;
            iter_count_q <= '0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            done_q       <= done_d;
            winner_q     <= winner_d;
            zero_all_q   <= zero_all_d;
            timeout_q    <= timeout_d;
            iter_count_q <= iter_count_d;
        end
    end

    assign init_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign iter_start = (state_q == S_LAUNCH);
    assign a1         = act_q[0];
    assign a2         = act_q[1];
    assign a3         = act_q[2];
    assign a4         = act_q[3];
    assign done       = done_q;
    assign winner     = winner_q;
    assign zero_all   = zero_all_q;
    assign timeout    = timeout_q;
    assign iter_count = iter_count_q;

endmodule
